// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a 2-flop input synchroniser, mid-bit
// sampling driven by a per-bit cycle counter, a valid/ready output handshake,
// and single-cycle framing_error / overrun pulses.
module uart_receiver #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   // Last count of a full bit period, and of half a period (start-bit centre).
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   // Fewer than 4 clocks per bit leaves no usable mid-bit margin.
   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_ratio
         $error("uart_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic             sync1;
   logic             rx;
   logic             rx_prev;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   // Two-flop synchroniser for the asynchronous line, plus a delayed copy of rx
   // so the idle state can see a clean 1->0 start edge. All reset to idle-high.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b1;
         rx      <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= serial_in;
         rx      <= sync1;
         rx_prev <= rx;
      end
   end

   // Receive FSM, output register and handshake. Error pulses default low so
   // they last exactly one cycle; a byte load overrides a same-cycle consume.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         bit_idx        <= '0;
         shreg          <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         framing_error  <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;
         if (data_out_valid && data_out_ready)
            data_out_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_prev && !rx) begin
                  state <= START;
                  cnt   <= '0;
               end
            end

            START: begin
               // Re-check the line at the start-bit centre; a high line here
               // was a glitch and is dropped silently.
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rx, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            STOP: begin
               // Decide at mid stop bit and go idle immediately so a
               // back-to-back start edge is not missed.
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (!rx) begin
                     framing_error <= 1'b1;
                  end else if (!data_out_valid || data_out_ready) begin
                     data_out       <= shreg;
                     data_out_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scenario tasks driving 8N1 frames into uart_receiver
// (CLKS_PER_BIT = 10) and checking against expectations derived from the
// frame contents and the consumer's ready behaviour.
module tb_uart_receiver;

   localparam int CPB = 10;

   logic       sysclk = 1'b0;
   logic       rst_n;
   logic       serial_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       framing_error;
   logic       overrun;

   int pass_cnt  = 0;
   int total_cnt = 0;

   int cyc = 0;
   int last_start;

   // Monitor state: accepted bytes, valid rises, error pulse cycles and edges.
   logic [7:0] acc_q[$];
   int  rise_cnt, rise_cyc, fe_cyc, fe_edges, ov_cyc, ov_edges, clash_cnt;
   logic valid_d, fe_d, ov_d;

   uart_receiver #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
      .sysclk         (sysclk),
      .rst_n          (rst_n),
      .serial_in      (serial_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .framing_error  (framing_error),
      .overrun        (overrun)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge sysclk) begin
      if (data_out_valid && data_out_ready) acc_q.push_back(data_out);
      if (data_out_valid && !valid_d) begin
         rise_cnt = rise_cnt + 1;
         rise_cyc = cyc;
         if (framing_error || overrun) clash_cnt = clash_cnt + 1;
      end
      if (framing_error) fe_cyc = fe_cyc + 1;
      if (framing_error && !fe_d) fe_edges = fe_edges + 1;
      if (overrun) ov_cyc = ov_cyc + 1;
      if (overrun && !ov_d) ov_edges = ov_edges + 1;
      valid_d = data_out_valid;
      fe_d    = framing_error;
      ov_d    = overrun;
   end

   task automatic clear_mon();
      acc_q.delete();
      rise_cnt = 0; rise_cyc = 0;
      fe_cyc = 0; fe_edges = 0; ov_cyc = 0; ov_edges = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   // One frame: start bit, 8 data bits LSB first, stop bit; line left high.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         serial_in = bits[i];
         if (i == 0) last_start = cyc;
         idle(CPB);
      end
      serial_in = 1'b1;
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0; serial_in = 1'b1; data_out_ready = 1'b0;
      valid_d = 1'b0; fe_d = 1'b0; ov_d = 1'b0; clash_cnt = 0;
      clear_mon();
      idle(3);
      total_cnt++;
      if ({data_out_valid, framing_error, overrun, data_out} !== 11'h0)
         $display("FAIL reset_outputs: got %h want 0", {data_out_valid, framing_error, overrun, data_out});
      else pass_cnt++;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         idle(1);
         if ({data_out_valid, framing_error, overrun, data_out} !== 11'h0) bad++;
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL idle_outputs: got %0d nonzero cycles want 0", bad);
      else pass_cnt++;
   endtask

   task automatic test_hold();
      int bad;
      data_out_ready = 1'b0;
      clear_mon();
      send_frame(8'hA5, 1'b1);
      total_cnt++;
      if (rise_cnt !== 1 || rise_cyc - last_start < 97 || rise_cyc - last_start > 99)
         $display("FAIL hold_latency: got %0d rises, latency %0d want 1 rise, 97..99", rise_cnt, rise_cyc - last_start);
      else pass_cnt++;
      total_cnt++;
      if (data_out !== 8'hA5) $display("FAIL hold_data: got %h want a5", data_out);
      else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         idle(1);
         if (data_out_valid !== 1'b1 || data_out !== 8'hA5) bad++;
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
      else pass_cnt++;
      data_out_ready = 1'b1;
      idle(1);
      data_out_ready = 1'b0;
      total_cnt++;
      if (data_out_valid !== 1'b0) $display("FAIL hold_consume: got valid=%b want 0", data_out_valid);
      else pass_cnt++;
      total_cnt++;
      if (acc_q.size() !== 1 || acc_q[0] !== 8'hA5)
         $display("FAIL hold_accepted: got %0d bytes want 1 (a5)", acc_q.size());
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      data_out_ready = 1'b1;
      clear_mon();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      total_cnt++;
      if (acc_q.size() !== 2 || acc_q[0] !== 8'h00 || acc_q[1] !== 8'hFF)
         $display("FAIL b2b_bytes: got %0d bytes want 00,ff", acc_q.size());
      else pass_cnt++;
      total_cnt++;
      if (rise_cnt !== 2 || fe_cyc !== 0 || ov_cyc !== 0)
         $display("FAIL b2b_pulses: got rises=%0d fe=%0d ov=%0d want 2,0,0", rise_cnt, fe_cyc, ov_cyc);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      data_out_ready = 1'b1;
      clear_mon();
      serial_in = 1'b0;
      idle(3);
      serial_in = 1'b1;
      idle(20);
      total_cnt++;
      if (rise_cnt !== 0 || fe_cyc !== 0) $display("FAIL glitch_ignored: got rises=%0d fe=%0d want 0,0", rise_cnt, fe_cyc);
      else pass_cnt++;
      send_frame(8'h3C, 1'b1);
      idle(20);
      total_cnt++;
      if (acc_q.size() !== 1 || acc_q[0] !== 8'h3C)
         $display("FAIL glitch_next: got %0d bytes want 1 (3c)", acc_q.size());
      else pass_cnt++;
   endtask

   task automatic test_framing();
      data_out_ready = 1'b1;
      clear_mon();
      send_frame(8'h55, 1'b0);
      idle(20);
      total_cnt++;
      if (fe_edges !== 1 || fe_cyc !== 1 || rise_cnt !== 0)
         $display("FAIL framing_pulse: got edges=%0d cycles=%0d rises=%0d want 1,1,0", fe_edges, fe_cyc, rise_cnt);
      else pass_cnt++;
      send_frame(8'h81, 1'b1);
      idle(20);
      total_cnt++;
      if (acc_q.size() !== 1 || acc_q[0] !== 8'h81 || fe_cyc !== 1)
         $display("FAIL framing_next: got %0d bytes fe=%0d want 1 byte (81), fe 1", acc_q.size(), fe_cyc);
      else pass_cnt++;
   endtask

   task automatic test_overrun_reset();
      logic [7:0] pb;
      data_out_ready = 1'b0;
      clear_mon();
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      idle(5);
      total_cnt++;
      if (data_out_valid !== 1'b1 || data_out !== 8'h12)
         $display("FAIL overrun_keep: got valid=%b data=%h want 1,12", data_out_valid, data_out);
      else pass_cnt++;
      total_cnt++;
      if (ov_edges !== 1 || ov_cyc !== 1 || fe_cyc !== 0)
         $display("FAIL overrun_pulse: got edges=%0d cycles=%0d fe=%0d want 1,1,0", ov_edges, ov_cyc, fe_cyc);
      else pass_cnt++;
      // Partial frame, reset lands in the middle of data bit 4.
      pb = 8'hC3;
      serial_in = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         serial_in = pb[i];
         idle(CPB);
      end
      serial_in = pb[4];
      idle(5);
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (data_out_valid !== 1'b0 || data_out !== 8'h00)
         $display("FAIL reset_midframe: got valid=%b data=%h want 0,00", data_out_valid, data_out);
      else pass_cnt++;
      serial_in = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(30);
      clear_mon();
      data_out_ready = 1'b1;
      send_frame(8'h7E, 1'b1);
      idle(20);
      total_cnt++;
      if (acc_q.size() !== 1 || acc_q[0] !== 8'h7E || fe_cyc !== 0 || ov_cyc !== 0)
         $display("FAIL reset_recover: got %0d bytes fe=%0d ov=%0d want 1 (7e),0,0", acc_q.size(), fe_cyc, ov_cyc);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      data_out_ready = 1'b1;
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_frame(b, 1'b1);
         idle($urandom_range(0, 12));
      end
      idle(20);
      total_cnt++;
      if (acc_q.size() !== exp_q.size())
         $display("FAIL rand_count: got %0d bytes want %0d", acc_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
         total_cnt++;
         if (acc_q[i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (clash_cnt !== 0) $display("FAIL error_with_load: got %0d want 0", clash_cnt);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_hold();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_overrun_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
